// File: rtl/counter_sweep_ctrl_pkg.sv
// rtl/counter_sweep_ctrl_pkg.sv - shared state encoding and default width for the sweep controller
package counter_sweep_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/updown_cnt.sv
// rtl/updown_cnt.sv - loadable up/down counter, wraps modulo 2^WIDTH when left enabled
module updown_cnt
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             UpOrDown,
  output logic [WIDTH-1:0] Count
);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      Count <= '0;
    end else if (load) begin
      Count <= d;
    end else if (en) begin
      Count <= UpOrDown ? Count + WIDTH'(1) : Count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - runs n up-then-down sweeps between captured bounds lo and hi
module counter_sweep_ctrl
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] n_sweeps,
  output logic [WIDTH-1:0] Count,
  output logic             UpOrDown,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] sweeps_done
);

  state_t           state;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] ns_q;
  logic             start_ok;
  logic             at_top;
  logic             at_bottom;
  logic             sweep_end;
  logic             cnt_en;
  logic             cnt_load;
  logic             cnt_dir;
  logic [WIDTH-1:0] cnt_d;

  assign start_ok  = (lo < hi) && (n_sweeps != '0);
  assign at_top    = (Count == hi_q);
  assign at_bottom = (Count == lo_q + WIDTH'(1));
  // With hi == lo+1 there is no down leg, so the sweep closes at the top.
  assign sweep_end = ((state == UP) && at_top && at_bottom) ||
                     ((state == DOWN) && at_bottom);

  always_comb begin
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_dir  = 1'b0;
    cnt_d    = lo_q;
    case (state)
      IDLE: begin
        if (start && start_ok) begin
          cnt_load = 1'b1;
          cnt_d    = lo;
        end
      end
      UP: begin
        if (!abort) begin
          if (sweep_end) begin
            cnt_load = 1'b1;
          end else if (at_top) begin
            cnt_load = 1'b1;
            cnt_d    = hi_q - WIDTH'(1);
          end else begin
            cnt_en  = 1'b1;
            cnt_dir = 1'b1;
          end
        end
      end
      DOWN: begin
        if (!abort) begin
          if (sweep_end) begin
            cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      ns_q        <= '0;
      sweeps_done <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              lo_q        <= lo;
              hi_q        <= hi;
              ns_q        <= n_sweeps;
              sweeps_done <= '0;
              state       <= UP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        UP, DOWN: begin
          if (abort) begin
            state <= IDLE;
          end else if (sweep_end) begin
            sweeps_done <= sweeps_done + WIDTH'(1);
            state       <= (sweeps_done + WIDTH'(1) == ns_q) ? DONE : UP;
          end else if ((state == UP) && at_top) begin
            state <= DOWN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == UP) || (state == DOWN);
  assign UpOrDown = (state == UP);
  assign done     = (state == DONE);

  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .Clk      (Clk),
    .reset    (reset),
    .en       (cnt_en),
    .load     (cnt_load),
    .d        (cnt_d),
    .UpOrDown (cnt_dir),
    .Count    (Count)
  );

endmodule
